// File: rtl/fp_adder_arbiter.sv
// Round-robin front end for one shared FP adder/converter: registers the granted
// operands into the adder, tracks a tag per in-flight op and queues results in order.
module fp_adder_arbiter #(
    parameter int size_mantissa        = 24,
    parameter int size_exponent        = 8,
    parameter int size_exception_field = 2,
    parameter int size                 = size_mantissa + size_exponent + size_exception_field,
    parameter int NUM_REQ              = 4,
    parameter int ID_W                 = 2,
    parameter int ADDER_LATENCY        = 0,
    parameter int RESP_DEPTH           = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*size-1:0]   req_a,
    input  logic [NUM_REQ*size-1:0]   req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    input  logic [2*NUM_REQ-1:0]      req_conversion,
    output logic [size-1:0]           add_a,
    output logic [size-1:0]           add_b,
    output logic                      add_sub,
    output logic [1:0]                add_conversion,
    input  logic [size-1:0]           add_result,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [size-1:0]           resp_number
);

    localparam int IDP_W = ID_W + 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = $clog2(RESP_DEPTH);

    logic [size-1:0] a_slice    [NUM_REQ];
    logic [size-1:0] b_slice    [NUM_REQ];
    logic [1:0]      conv_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_slice[gi]    = req_a[gi*size +: size];
            assign b_slice[gi]    = req_b[gi*size +: size];
            assign conv_slice[gi] = req_conversion[2*gi +: 2];
        end
    endgenerate

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [size-1:0]  add_a_q, add_a_d;
    logic [size-1:0]  add_b_q, add_b_d;
    logic             add_sub_q, add_sub_d;
    logic [1:0]       add_conversion_q, add_conversion_d;
    logic [ADDER_LATENCY:0]           tag_valid_q, tag_valid_d;
    logic [ADDER_LATENCY:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [CNT_W-1:0] inflight_cnt_q, inflight_cnt_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [size-1:0]  fifo_num_mem [RESP_DEPTH];
    logic [ID_W-1:0]  fifo_id_mem  [RESP_DEPTH];

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [IDP_W-1:0] cand;
    logic [CNT_W:0]   occupancy;
    logic             credit_ok;
    logic             accept;
    logic             capture;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + IDP_W'(k);
            if (cand >= IDP_W'(NUM_REQ)) begin
                cand = cand - IDP_W'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // Credit counts every op that will eventually need a FIFO slot.
    assign occupancy = {1'b0, inflight_cnt_q} + {1'b0, fifo_cnt_q};
    assign credit_ok = occupancy < (CNT_W+1)'(RESP_DEPTH);
    assign accept    = !rst && credit_ok && grant_found;

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = accept;
    end

    assign capture    = tag_valid_q[ADDER_LATENCY];
    assign push       = capture;
    assign resp_valid = (fifo_cnt_q != '0);
    assign pop        = resp_valid && resp_ready;

    always_comb begin
        rr_ptr_d         = rr_ptr_q;
        add_a_d          = add_a_q;
        add_b_d          = add_b_q;
        add_sub_d        = add_sub_q;
        add_conversion_d = add_conversion_q;
        if (accept) begin
            rr_ptr_d         = grant_id;
            add_a_d          = a_slice[grant_id];
            add_b_d          = b_slice[grant_id];
            add_sub_d        = req_sub[grant_id];
            add_conversion_d = conv_slice[grant_id];
        end

        tag_valid_d    = '0;
        tag_id_d       = '0;
        tag_valid_d[0] = accept;
        tag_id_d[0]    = grant_id;
        for (int i = 1; i <= ADDER_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end

        inflight_cnt_d = inflight_cnt_q;
        if (accept && !capture) begin
            inflight_cnt_d = inflight_cnt_q + CNT_W'(1);
        end else if (!accept && capture) begin
            inflight_cnt_d = inflight_cnt_q - CNT_W'(1);
        end

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q         <= ID_W'(NUM_REQ - 1);
            add_a_q          <= '0;
            add_b_q          <= '0;
            add_sub_q        <= 1'b0;
            add_conversion_q <= '0;
            tag_valid_q      <= '0;
            tag_id_q         <= '0;
            inflight_cnt_q   <= '0;
            fifo_cnt_q       <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            add_a_q          <= add_a_d;
            add_b_q          <= add_b_d;
            add_sub_q        <= add_sub_d;
            add_conversion_q <= add_conversion_d;
            tag_valid_q      <= tag_valid_d;
            tag_id_q         <= tag_id_d;
            inflight_cnt_q   <= inflight_cnt_d;
            fifo_cnt_q       <= fifo_cnt_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in fifo_cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_num_mem[wr_ptr_q] <= add_result;
            fifo_id_mem[wr_ptr_q]  <= tag_id_q[ADDER_LATENCY];
        end
    end

    assign resp_id        = fifo_id_mem[rd_ptr_q];
    assign resp_number    = fifo_num_mem[rd_ptr_q];
    assign add_a          = add_a_q;
    assign add_b          = add_b_q;
    assign add_sub        = add_sub_q;
    assign add_conversion = add_conversion_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: a zero-latency instance for most traffic and a
// two-stage-adder instance for the reset-while-busy sequence.
module tb_fp_adder_arbiter;

    localparam int SZ    = 34;
    localparam int NR    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, rst2;
    logic [NR-1:0]     req_valid, req_ready, req_valid2, req_ready2;
    logic [NR*SZ-1:0]  req_a, req_b, req_a2, req_b2;
    logic [NR-1:0]     req_sub, req_sub2;
    logic [2*NR-1:0]   req_conv, req_conv2;
    logic [SZ-1:0]     add_a, add_b, add_a2, add_b2;
    logic              add_sub, add_sub2;
    logic [1:0]        add_conv, add_conv2;
    logic [SZ-1:0]     add_result, add_result2;
    logic              resp_valid, resp_ready, resp_valid2, resp_ready2;
    logic [1:0]        resp_id, resp_id2;
    logic [SZ-1:0]     resp_number, resp_number2;
    logic [SZ-1:0]     s1, s2;

    fp_adder_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_conversion(req_conv),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_conversion(add_conv),
        .add_result(add_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_number(resp_number)
    );

    fp_adder_arbiter #(.ADDER_LATENCY(2), .RESP_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2), .req_sub(req_sub2), .req_conversion(req_conv2),
        .add_a(add_a2), .add_b(add_b2), .add_sub(add_sub2), .add_conversion(add_conv2),
        .add_result(add_result2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_id(resp_id2), .resp_number(resp_number2)
    );

    // Stand-in for the external adder: exact for equal-operand add/sub, otherwise
    // an operand-order-sensitive scramble so misrouted fields show up.
    function automatic logic [SZ-1:0] stub(input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                                           input logic s, input logic [1:0] c);
        if (c == 2'b00 && a == b) return s ? '0 : a + 34'h000800000;
        return a ^ {b[16:0], b[33:17]} ^ {31'h0, c, s};
    endfunction

    always_comb add_result = stub(add_a, add_b, add_sub, add_conv);
    always @(posedge clk) begin
        s1 <= stub(add_a2, add_b2, add_sub2, add_conv2);
        s2 <= s1;
    end
    assign add_result2 = s2;

    typedef struct { logic [1:0] id; logic [SZ-1:0] num; } exp_t;
    typedef struct {
        int id; logic [SZ-1:0] a; logic [SZ-1:0] b; logic sub; logic [1:0] conv;
        logic [1:0] exp_id; logic [SZ-1:0] exp_num;
    } vec_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs applied; observes, updates the scoreboard,
    // and returns at the following negedge.
    task automatic step(output int gnt, output bit got, output logic [1:0] rid,
                        output logic [SZ-1:0] rnum);
        exp_t e;
        #2;
        gnt = -1; got = 1'b0; rid = '0; rnum = '0;
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        chk("occupancy_le_depth", 64'(sb.size() <= DEPTH), 64'd1);
        if (resp_valid) begin
            chk("resp_has_outstanding", 64'(sb.size() != 0), 64'd1);
            if (resp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                got = 1'b1; rid = resp_id; rnum = resp_number;
                chk("sb_resp_id", 64'(resp_id), 64'(e.id));
                chk("sb_resp_number", 64'(resp_number), 64'(e.num));
                $display("resp  id=%0d number=0x%09h", resp_id, resp_number);
            end
        end
        for (int g = 0; g < NR; g++) begin
            if (req_ready[g]) begin
                gnt = g;
                chk("ready_implies_valid", 64'(req_valid[g]), 64'd1);
                e.id  = 2'(g);
                e.num = stub(req_a[g*SZ +: SZ], req_b[g*SZ +: SZ], req_sub[g], req_conv[2*g +: 2]);
                sb.push_back(e);
                $display("issue id=%0d a=0x%09h b=0x%09h sub=%0d conv=%0d", g,
                         req_a[g*SZ +: SZ], req_b[g*SZ +: SZ], req_sub[g], req_conv[2*g +: 2]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[5];
        int g, dg, n, k, acc2, rsp2;
        bit got, acc;
        logic [1:0] rid;
        logic [SZ-1:0] rnum;

        vecs[0] = '{1, 34'h13F800000, 34'h13F800000, 1'b0, 2'b00, 2'd1, 34'h140000000};
        vecs[1] = '{2, 34'h140000000, 34'h140000000, 1'b1, 2'b00, 2'd2, 34'h000000000};
        vecs[2] = '{0, 34'h0DEADBEE, 34'h012345678, 1'b0, 2'b01, 2'd0,
                    stub(34'h0DEADBEE, 34'h012345678, 1'b0, 2'b01)};
        vecs[3] = '{3, 34'h000000055, 34'h2AAAA0000, 1'b1, 2'b10, 2'd3,
                    stub(34'h000000055, 34'h2AAAA0000, 1'b1, 2'b10)};
        vecs[4] = '{3, 34'h1C0FFEE00, 34'h000F00F00, 1'b0, 2'b11, 2'd3,
                    stub(34'h1C0FFEE00, 34'h000F00F00, 1'b0, 2'b11)};

        rst = 1'b1; rst2 = 1'b1;
        req_valid = '1; req_valid2 = '1;
        req_a = '0; req_b = '0; req_sub = '0; req_conv = '0;
        req_a2 = '0; req_b2 = '0; req_sub2 = '0; req_conv2 = '0;
        resp_ready = 1'b0; resp_ready2 = 1'b0;

        // Reset held for two edges with every request valid.
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            #2;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_req_ready2", 64'(req_ready2), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_add_a", 64'(add_a), 64'd0);
            chk("rst_add_b", 64'(add_b), 64'd0);
            chk("rst_add_sub_conv", 64'({add_sub, add_conv}), 64'd0);
            if (r == 0) @(negedge clk);
        end
        rst = 1'b0; rst2 = 1'b0;
        req_valid = '0; req_valid2 = '0;
        resp_ready = 1'b1;
        @(negedge clk);

        // Single operations, one at a time, with latency check.
        foreach (vecs[v]) begin
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_a[vecs[v].id*SZ +: SZ] = vecs[v].a;
            req_b[vecs[v].id*SZ +: SZ] = vecs[v].b;
            req_sub[vecs[v].id] = vecs[v].sub;
            req_conv[2*vecs[v].id +: 2] = vecs[v].conv;
            g = -1; n = 0;
            while (g < 0 && n < 10) begin step(g, got, rid, rnum); n++; end
            chk($sformatf("vec%0d_grant", v), 64'(g), 64'(vecs[v].id));
            req_valid = '0;
            k = 0; got = 1'b0;
            while (!got && k < 10) begin step(dg, got, rid, rnum); k++; end
            chk($sformatf("vec%0d_latency", v), 64'(k), 64'd2);
            chk($sformatf("vec%0d_resp_id", v), 64'(rid), 64'(vecs[v].exp_id));
            chk($sformatf("vec%0d_resp_number", v), 64'(rnum), 64'(vecs[v].exp_num));
        end

        // Round-robin from a fresh reset: 0,1,2,3,0,1 back to back.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < NR; i++) begin
            req_a[i*SZ +: SZ] = 34'h100000000 + 34'(i * 273);
            req_b[i*SZ +: SZ] = 34'(i * 8192 + 7);
            req_sub[i] = i[0];
            req_conv[2*i +: 2] = 2'(i % 3);
        end
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            step(g, got, rid, rnum);
            chk($sformatf("rr_grant%0d", i), 64'(g), 64'(i % NR));
        end
        req_valid = '0;
        n = 0;
        while (sb.size() > 0 && n < 30) begin step(dg, got, rid, rnum); n++; end
        chk("rr_drained", 64'(sb.size()), 64'd0);

        // Backpressure: exactly DEPTH accepts, then stall until responses drain.
        resp_ready = 1'b0;
        req_valid = '1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(g, got, rid, rnum);
            if (g >= 0) n++;
        end
        chk("bp_accepts", 64'(n), 64'(DEPTH));
        #2;
        chk("bp_ready_zero", 64'(req_ready), 64'd0);
        chk("bp_resp_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);
        resp_ready = 1'b1;
        acc2 = 0; rsp2 = 0;
        for (int i = 0; i < 12; i++) begin
            step(g, got, rid, rnum);
            if (g >= 0) acc2++;
            if (got) rsp2++;
        end
        chk("bp_resume_accepts", 64'(acc2 > 0), 64'd1);
        chk("bp_resp_at_least_depth", 64'(rsp2 >= DEPTH), 64'd1);
        req_valid = '0;
        n = 0;
        while (sb.size() > 0 && n < 30) begin step(dg, got, rid, rnum); n++; end
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Two-stage adder: reset while three ops are in flight.
        for (int i = 0; i < 3; i++) begin
            req_a2[i*SZ +: SZ] = 34'h100000100 + 34'(i);
            req_b2[i*SZ +: SZ] = 34'h000000200 + 34'(i);
        end
        req_valid2 = 4'b0111;
        resp_ready2 = 1'b0;
        n = 0;
        for (int t = 0; t < 10 && n < 3; t++) begin
            #2;
            if (|req_ready2) begin
                n++;
                $display("issue2 ready=%b", req_ready2);
            end
            @(negedge clk);
        end
        req_valid2 = '0;
        chk("l2_accepts", 64'(n), 64'd3);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        k = 0;
        for (int t = 0; t < 10; t++) begin
            #2;
            if (resp_valid2) k++;
            @(negedge clk);
        end
        chk("l2_no_resp_after_reset", 64'(k), 64'd0);

        req_a2[3*SZ +: SZ] = 34'h13F800000;
        req_b2[3*SZ +: SZ] = 34'h13F800000;
        req_sub2[3] = 1'b0;
        req_conv2[7:6] = 2'b00;
        req_valid2 = 4'b1000;
        resp_ready2 = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 10 && !acc; t++) begin
            #2;
            if (req_ready2[3]) acc = 1'b1;
            @(negedge clk);
        end
        req_valid2 = '0;
        chk("l2_new_grant", 64'(acc), 64'd1);
        k = 0; got = 1'b0;
        while (!got && k < 12) begin
            k++;
            #2;
            if (resp_valid2) begin
                got = 1'b1; rid = resp_id2; rnum = resp_number2;
                $display("resp2 id=%0d number=0x%09h", resp_id2, resp_number2);
            end
            @(negedge clk);
        end
        chk("l2_latency", 64'(k), 64'd4);
        chk("l2_resp_id", 64'(rid), 64'd3);
        chk("l2_resp_number", 64'(rnum), 64'h140000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
